// File: rtl/sd_dat_phys_controller_mb.sv
// Multi-block SD DAT-line physical controller: sequences the serializer/deserializer
// wrapper, DAT pads and data FIFO for block reads/writes with CRC-status and timeout handling.
module sd_dat_phys_controller_mb #(
  parameter int DATA_W = 32,
  parameter int BLK_W  = 8,
  parameter int TO_W   = 16
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              strobe_in,
  input  logic              ack_in,
  input  logic              idle_in,
  input  logic              write_read,
  input  logic              multiple,
  input  logic [BLK_W-1:0]  blocks,
  input  logic [TO_W-1:0]   timeout_reg,
  output logic              serial_ready,
  output logic              complete,
  output logic              ack_out,
  output logic              data_timeout,
  output logic              crc_error,
  output logic [BLK_W-1:0]  blocks_done,
  input  logic              transmission_complete,
  input  logic              reception_complete,
  input  logic              crc_ok,
  input  logic [DATA_W-1:0] data_read,
  output logic              reset_wrapper,
  output logic              load_send,
  output logic              enable_pts_wrapper,
  output logic              enable_stp_wrapper,
  output logic              waiting_response,
  output logic [DATA_W-1:0] data_parallel,
  output logic              pad_state,
  output logic              pad_enable,
  input  logic [DATA_W-1:0] data_from_fifo,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              fifo_pop,
  output logic              fifo_push,
  output logic [DATA_W-1:0] data_to_fifo
);

  typedef enum logic [3:0] {
    S_IDLE, S_FIFO_POP, S_LOAD, S_SEND, S_WAIT_RESP,
    S_READ, S_PUSH, S_BLK_RESET, S_WAIT_ACK, S_SEND_ACK
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d, multi_q, multi_d;
  logic              to_flag_q, to_flag_d, crc_err_q, crc_err_d;
  logic [BLK_W-1:0]  blk_req_q, blk_req_d, blk_done_q, blk_done_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] dpar_q, dpar_d, dfifo_q, dfifo_d;
  logic [BLK_W-1:0]  blk_inc;
  logic [TO_W-1:0]   cnt_inc;
  logic              xfer_done, rx_active;

  function automatic logic [BLK_W-1:0] sat_inc_blk(input logic [BLK_W-1:0] b);
    return (b == '1) ? b : b + BLK_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] c,
                                                  input logic [TO_W-1:0] lim);
    return (c >= lim) ? lim : c + TO_W'(1);
  endfunction

  assign blk_inc   = sat_inc_blk(blk_done_q);
  assign cnt_inc   = sat_inc_to(to_cnt_q, timeout_reg);
  assign xfer_done = !multi_q || (blk_inc >= blk_req_q);

  always_comb begin
    state_d            = state_q;
    wr_d               = wr_q;
    multi_d            = multi_q;
    blk_req_d          = blk_req_q;
    blk_done_d         = blk_done_q;
    to_flag_d          = to_flag_q;
    crc_err_d          = crc_err_q;
    to_cnt_d           = '0;
    dpar_d             = dpar_q;
    dfifo_d            = dfifo_q;
    rx_active          = 1'b0;
    serial_ready       = 1'b0;
    complete           = 1'b0;
    ack_out            = 1'b0;
    reset_wrapper      = 1'b0;
    load_send          = 1'b0;
    enable_pts_wrapper = 1'b0;
    enable_stp_wrapper = 1'b0;
    waiting_response   = 1'b0;
    pad_state          = 1'b0;
    pad_enable         = 1'b0;
    fifo_pop           = 1'b0;
    fifo_push          = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_ready  = 1'b1;
        reset_wrapper = 1'b1;
        if (strobe_in) begin
          wr_d       = write_read;
          multi_d    = multiple;
          blk_req_d  = (blocks == '0) ? BLK_W'(1) : blocks;
          blk_done_d = '0;
          to_flag_d  = 1'b0;
          crc_err_d  = 1'b0;
          state_d    = write_read ? S_FIFO_POP : S_READ;
        end
      end
      S_FIFO_POP: begin
        pad_state  = 1'b1;
        pad_enable = 1'b1;
        fifo_pop   = !fifo_empty;
        if (!fifo_empty) begin
          dpar_d  = data_from_fifo;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Pads stay driven between the pop and the serial shift.
        enable_pts_wrapper = 1'b1;
        pad_state          = 1'b1;
        pad_enable         = 1'b1;
        state_d            = S_SEND;
      end
      S_SEND: begin
        load_send          = 1'b1;
        enable_pts_wrapper = 1'b1;
        pad_state          = 1'b1;
        pad_enable         = 1'b1;
        if (transmission_complete) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        enable_stp_wrapper = 1'b1;
        waiting_response   = 1'b1;
        pad_enable         = 1'b1;
        rx_active          = 1'b1;
        if (reception_complete) begin
          if (!crc_ok) begin
            crc_err_d = 1'b1;
            state_d   = S_WAIT_ACK;
          end else begin
            blk_done_d = blk_inc;
            state_d    = xfer_done ? S_WAIT_ACK : S_BLK_RESET;
          end
        end else if (to_flag_q) begin
          state_d = S_WAIT_ACK;
        end
      end
      S_READ: begin
        enable_stp_wrapper = 1'b1;
        pad_enable         = 1'b1;
        rx_active          = 1'b1;
        if (reception_complete) begin
          dfifo_d = data_read;
          state_d = S_PUSH;
        end else if (to_flag_q) begin
          state_d = S_WAIT_ACK;
        end
      end
      S_PUSH: begin
        fifo_push = !fifo_full;
        if (!fifo_full) begin
          blk_done_d = blk_inc;
          state_d    = xfer_done ? S_WAIT_ACK : S_BLK_RESET;
        end
      end
      S_BLK_RESET: begin
        reset_wrapper = 1'b1;
        state_d       = wr_q ? S_FIFO_POP : S_READ;
      end
      S_WAIT_ACK: begin
        complete      = 1'b1;
        reset_wrapper = 1'b1;
        if (ack_in) state_d = S_SEND_ACK;
      end
      S_SEND_ACK: begin
        complete = 1'b1;
        ack_out  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flag is raised on the edge the count reaches the limit; the exit follows one cycle later.
    if (rx_active && !reception_complete && !to_flag_q) begin
      to_cnt_d = cnt_inc;
      if ((timeout_reg != '0) && (cnt_inc == timeout_reg)) to_flag_d = 1'b1;
    end

    if (idle_in) begin
      state_d    = S_IDLE;
      to_flag_d  = 1'b0;
      crc_err_d  = 1'b0;
      blk_done_d = '0;
      to_cnt_d   = '0;
      dpar_d     = '0;
      dfifo_d    = '0;
    end
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      multi_q    <= 1'b0;
      blk_req_q  <= '0;
      blk_done_q <= '0;
      to_flag_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      to_cnt_q   <= '0;
      dpar_q     <= '0;
      dfifo_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      multi_q    <= multi_d;
      blk_req_q  <= blk_req_d;
      blk_done_q <= blk_done_d;
      to_flag_q  <= to_flag_d;
      crc_err_q  <= crc_err_d;
      to_cnt_q   <= to_cnt_d;
      dpar_q     <= dpar_d;
      dfifo_q    <= dfifo_d;
    end
  end

  assign data_timeout  = to_flag_q;
  assign crc_error     = crc_err_q;
  assign blocks_done   = blk_done_q;
  assign data_parallel = dpar_q;
  assign data_to_fifo  = dfifo_q;

endmodule

// File: tb/tb_sd_dat_phys_controller_mb.sv
// Directed-sequence bench for sd_dat_phys_controller_mb with randomized data, delays and
// block counts; expectations come from a transfer-level model of the controller's rules.
module tb_sd_dat_phys_controller_mb;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int TW = 16;
  localparam logic [13:0] IDLE_CTL = 14'b11_0000_0000_0000;

  logic          sd_clock = 1'b0;
  logic          reset, strobe_in, ack_in, idle_in, write_read, multiple;
  logic [BW-1:0] blocks;
  logic [TW-1:0] timeout_reg;
  logic          serial_ready, complete, ack_out, data_timeout, crc_error;
  logic [BW-1:0] blocks_done;
  logic          transmission_complete, reception_complete, crc_ok;
  logic [DW-1:0] data_read;
  logic          reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response;
  logic [DW-1:0] data_parallel;
  logic          pad_state, pad_enable;
  logic [DW-1:0] data_from_fifo;
  logic          fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic [DW-1:0] data_to_fifo;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int pushes = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pushq[$];

  sd_dat_phys_controller_mb #(.DATA_W(DW), .BLK_W(BW), .TO_W(TW)) dut (
    .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
    .idle_in(idle_in), .write_read(write_read), .multiple(multiple), .blocks(blocks),
    .timeout_reg(timeout_reg), .serial_ready(serial_ready), .complete(complete),
    .ack_out(ack_out), .data_timeout(data_timeout), .crc_error(crc_error),
    .blocks_done(blocks_done), .transmission_complete(transmission_complete),
    .reception_complete(reception_complete), .crc_ok(crc_ok), .data_read(data_read),
    .reset_wrapper(reset_wrapper), .load_send(load_send),
    .enable_pts_wrapper(enable_pts_wrapper), .enable_stp_wrapper(enable_stp_wrapper),
    .waiting_response(waiting_response), .data_parallel(data_parallel),
    .pad_state(pad_state), .pad_enable(pad_enable), .data_from_fifo(data_from_fifo),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_pop(fifo_pop),
    .fifo_push(fifo_push), .data_to_fifo(data_to_fifo)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ctl();
    return {serial_ready, reset_wrapper, complete, ack_out, data_timeout, crc_error,
            load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response,
            pad_state, pad_enable, fifo_pop, fifo_push};
  endfunction

  // One clock: sample strobes before the edge, then model the FIFO side effects.
  task automatic step();
    logic          p_pop, p_push;
    logic [DW-1:0] w;
    #1;
    p_pop  = fifo_pop;
    p_push = fifo_push;
    w      = data_to_fifo;
    @(posedge sd_clock);
    #1;
    if (p_pop) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pops++;
    end
    if (p_push) begin
      pushq.push_back(w);
      pushes++;
    end
    fifo_empty     = (fq.size() == 0);
    data_from_fifo = fifo_empty ? '0 : fq[0];
    #1;
  endtask

  task automatic fifo_put(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty     = 1'b0;
    data_from_fifo = fq[0];
  endtask

  task automatic start(input logic wr, input logic mult, input logic [BW-1:0] blk);
    write_read = wr;
    multiple   = mult;
    blocks     = blk;
    strobe_in  = 1'b1;
    step();
    strobe_in  = 1'b0;
  endtask

  task automatic ack_done(input string tag);
    chk({tag, "_wait_ack"}, {complete, ack_out}, 2'b10);
    repeat ($urandom_range(0, 2)) step();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    chk({tag, "_ack_out"}, {complete, ack_out}, 2'b11);
    step();
    chk({tag, "_idle"}, {serial_ready, ack_out, complete}, 3'b100);
  endtask

  task automatic write_xfer(input string tag, input logic mult, input logic [BW-1:0] blk,
                            input bit crc_bad, input logic [DW-1:0] w0, input bit use_w0);
    int            n, p0;
    logic [DW-1:0] w;
    n = mult ? ((blk == 0) ? 1 : int'(blk)) : 1;
    start(1'b1, mult, blk);
    for (int k = 1; k <= n; k++) begin
      w = (k == 1 && use_w0) ? w0 : $urandom;
      repeat ($urandom_range(0, 2)) begin
        chk({tag, "_pop_stall"}, fifo_pop, 1'b0);
        step();
      end
      fifo_put(w);
      #1;
      p0 = pops;
      chk({tag, "_pop"}, {fifo_pop, pad_state, pad_enable}, 3'b111);
      step();
      chk({tag, "_pop_cnt"}, pops, p0 + 1);
      chk({tag, "_load"}, {enable_pts_wrapper, load_send, fifo_pop}, 3'b100);
      chk({tag, "_dpar"}, data_parallel, w);
      step();
      chk({tag, "_send"}, {load_send, enable_pts_wrapper, pad_state, pad_enable}, 4'b1111);
      repeat ($urandom_range(0, 3)) step();
      transmission_complete = 1'b1;
      step();
      transmission_complete = 1'b0;
      chk({tag, "_wait_resp"}, {waiting_response, enable_stp_wrapper, pad_enable, pad_state}, 4'b1110);
      repeat ($urandom_range(0, 3)) step();
      crc_ok             = !crc_bad;
      reception_complete = 1'b1;
      step();
      reception_complete = 1'b0;
      crc_ok             = 1'b0;
      if (crc_bad) begin
        chk({tag, "_crc_err"}, {crc_error, complete}, 2'b11);
        chk({tag, "_crc_blk"}, blocks_done, 0);
        break;
      end
      chk({tag, "_blk_done"}, blocks_done, k);
      if (k < n) begin
        chk({tag, "_blk_reset"}, {reset_wrapper, serial_ready, complete}, 3'b100);
        step();
      end else begin
        chk({tag, "_complete"}, complete, 1'b1);
      end
    end
  endtask

  task automatic read_xfer(input string tag, input logic mult, input logic [BW-1:0] blk,
                           input int full_cycles, output int blk_resets);
    int            n, q0;
    logic [DW-1:0] w;
    n = mult ? ((blk == 0) ? 1 : int'(blk)) : 1;
    blk_resets = 0;
    start(1'b0, mult, blk);
    for (int k = 1; k <= n; k++) begin
      chk({tag, "_read_st"}, {enable_stp_wrapper, waiting_response, pad_enable, pad_state}, 4'b1010);
      repeat ($urandom_range(0, 4)) step();
      w                  = $urandom;
      data_read          = w;
      reception_complete = 1'b1;
      fifo_full          = (full_cycles > 0);
      step();
      reception_complete = 1'b0;
      data_read          = $urandom;
      q0 = pushes;
      for (int i = 0; i < full_cycles; i++) begin
        chk({tag, "_push_stall"}, fifo_push, 1'b0);
        step();
      end
      fifo_full = 1'b0;
      #1;
      chk({tag, "_push"}, fifo_push, 1'b1);
      step();
      chk({tag, "_push_cnt"}, pushes, q0 + 1);
      chk({tag, "_push_data"}, pushq[pushq.size()-1], w);
      chk({tag, "_push_once"}, fifo_push, 1'b0);
      chk({tag, "_blk_done"}, blocks_done, k);
      if (k < n) begin
        chk({tag, "_blk_reset"}, {reset_wrapper, serial_ready, complete}, 3'b100);
        blk_resets++;
        step();
      end else begin
        chk({tag, "_complete"}, complete, 1'b1);
      end
    end
  endtask

  initial begin
    int            nres, t, p0;
    logic [DW-1:0] w;
    reset = 1'b1; strobe_in = 1'b0; ack_in = 1'b0; idle_in = 1'b0;
    write_read = 1'b0; multiple = 1'b0; blocks = '0; timeout_reg = '0;
    transmission_complete = 1'b0; reception_complete = 1'b0; crc_ok = 1'b0;
    data_read = '0; data_from_fifo = '0; fifo_empty = 1'b1; fifo_full = 1'b0;
    step();
    step();
    chk("rst_ctl", ctl(), IDLE_CTL);
    chk("rst_bus", {data_parallel, data_to_fifo, blocks_done}, 0);
    reset = 1'b0;
    step();
    chk("idle_ctl", ctl(), IDLE_CTL);

    write_xfer("wr1", 1'b0, 8'd1, 1'b0, 32'hA5A5_0001, 1'b1);
    chk("wr1_total_pops", pops, 1);
    ack_done("wr1");

    write_xfer("wrm", 1'b1, 8'($urandom_range(2, 3)), 1'b0, '0, 1'b0);
    ack_done("wrm");
    write_xfer("wr0", 1'b1, 8'd0, 1'b0, '0, 1'b0);
    ack_done("wr0");

    pushq.delete();
    pushes = 0;
    read_xfer("rd3", 1'b1, 8'd3, 0, nres);
    chk("rd3_blk_resets", nres, 2);
    chk("rd3_pushes", pushes, 3);
    ack_done("rd3");

    read_xfer("rdfull", 1'b0, 8'($urandom_range(1, 5)), 5, nres);
    ack_done("rdfull");

    for (int r = 0; r < 2; r++) begin
      t = (r == 0) ? 4 : $urandom_range(1, 9);
      timeout_reg = TW'(t);
      start(1'b0, 1'b0, 8'd1);
      chk("to_c0", data_timeout, 1'b0);
      for (int c = 1; c < t; c++) begin
        step();
        chk("to_early", data_timeout, 1'b0);
      end
      step();
      chk("to_hit", {data_timeout, enable_stp_wrapper, complete}, 3'b110);
      step();
      chk("to_wait_ack", {data_timeout, complete}, 2'b11);
      ack_done("to");
      chk("to_sticky", {data_timeout, serial_ready}, 2'b11);
    end

    timeout_reg = '0;
    start(1'b0, 1'b0, 8'd1);
    chk("to0_clear", data_timeout, 1'b0);
    repeat (1000) step();
    chk("to0_hold", {data_timeout, enable_stp_wrapper, waiting_response, complete}, 4'b0100);
    idle_in = 1'b1;
    step();
    idle_in = 1'b0;
    chk("idle_rd_ctl", ctl(), IDLE_CTL);

    write_xfer("crc", 1'b1, 8'd2, 1'b1, '0, 1'b0);
    ack_done("crc");
    chk("crc_sticky", {crc_error, serial_ready}, 2'b11);

    w = $urandom | 32'h1;
    fifo_put(w);
    start(1'b1, 1'b0, 8'd1);
    chk("crc_cleared", crc_error, 1'b0);
    p0 = pops;
    step();
    chk("idl_pop", pops, p0 + 1);
    step();
    chk("idl_send", load_send, 1'b1);
    idle_in = 1'b1;
    step();
    idle_in = 1'b0;
    chk("idle_send_ctl", ctl(), IDLE_CTL);
    chk("idle_send_bus", {data_parallel, data_to_fifo, blocks_done}, 0);

    fifo_put($urandom | 32'h1);
    start(1'b1, 1'b0, 8'd1);
    step();
    step();
    transmission_complete = 1'b1;
    step();
    transmission_complete = 1'b0;
    chk("ar_wait_resp", waiting_response, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_async_ctl", ctl(), IDLE_CTL);
    chk("ar_async_bus", {data_parallel, data_to_fifo, blocks_done}, 0);
    step();
    chk("ar_held_ctl", ctl(), IDLE_CTL);
    reset = 1'b0;
    step();
    chk("ar_idle", ctl(), IDLE_CTL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sd_dat_phys_controller_mb.md
# sd_dat_phys_controller_mb

Parametrised multi-block SD DAT-line physical-layer controller, the next generation of the DAT phys controller. Sits between the host-side DAT command registers, the DAT serializer/deserializer wrapper, the DAT pad driver and the data FIFO. Adds configurable word/block-count/timeout widths, registered block counting, FIFO empty/full back-pressure, CRC-status abort, a disable-able saturating timeout and sticky error flags.

## Interface
- DATA_W, 32, data word width (FIFO and wrapper)
- BLK_W, 8, width of block-count request and counter
- TO_W, 16, width of timeout register and counter
- sd_clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- strobe_in  in  1  host transfer request
- ack_in  in  1  host accepts completion
- idle_in  in  1  synchronous abort to IDLE
- write_read  in  1  1 = write to card, 0 = read from card
- multiple  in  1  multi-block transfer
- blocks  in  BLK_W  block count; 0 treated as 1
- timeout_reg  in  TO_W  timeout in sd_clock cycles; 0 disables timeout
- serial_ready, complete, ack_out  out  1  host handshake
- data_timeout, crc_error  out  1  sticky error flags
- blocks_done  out  BLK_W  blocks completed in current transfer
- transmission_complete, reception_complete, crc_ok  in  1  from wrapper; crc_ok is valid with reception_complete
- data_read  in  DATA_W  deserialized word from wrapper
- reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response  out  1  to wrapper
- data_parallel  out  DATA_W  word to serializer
- pad_state, pad_enable  out  1  pad direction (1 = drive) and enable
- data_from_fifo  in  DATA_W  first-word-fall-through FIFO head
- fifo_empty, fifo_full  in  1  FIFO status
- fifo_pop, fifo_push  out  1  FIFO read / write strobes
- data_to_fifo  out  DATA_W  word pushed to FIFO

## Operation
- States: IDLE, FIFO_POP, LOAD, SEND, WAIT_RESP, READ, PUSH, BLK_RESET, WAIT_ACK, SEND_ACK. Outputs Moore-decoded from state, except fifo_pop and fifo_push, which are additionally qualified as stated.
- IDLE: serial_ready=1, reset_wrapper=1. On strobe_in, latch write_read, multiple and blocks (0 becomes 1), clear blocks_done and both error flags, then go to FIFO_POP (write) or READ (read).
- FIFO_POP: pad_state=pad_enable=1. fifo_pop = !fifo_empty. On a pop cycle, data_parallel <= data_from_fifo and next state is LOAD; otherwise stay in FIFO_POP.
- LOAD: enable_pts_wrapper=1 for one cycle, then SEND.
- SEND: load_send=enable_pts_wrapper=1, pads driven. Leave for WAIT_RESP on transmission_complete.
- WAIT_RESP: enable_stp_wrapper=waiting_response=1, pad_enable=1, pad_state=0, timeout active. On reception_complete:
  - crc_ok=0: set crc_error, go to WAIT_ACK.
  - crc_ok=1: increment blocks_done; if the transfer is done, go to WAIT_ACK, else go to BLK_RESET.
- READ: enable_stp_wrapper=1, pad_enable=1, pad_state=0, timeout active. On reception_complete, capture data_read into data_to_fifo, go to PUSH.
- PUSH: fifo_push = !fifo_full, asserted for exactly one cycle. Stall while fifo_full. On the push cycle, increment blocks_done; if the transfer is done, go to WAIT_ACK, else go to BLK_RESET.
- Transfer done: !multiple, or the incremented blocks_done >= latched blocks.
- BLK_RESET: reset_wrapper=1 for one cycle, then FIFO_POP (write) or READ (read).
- WAIT_ACK: complete=1, reset_wrapper=1, pads released. Go to SEND_ACK on ack_in.
- SEND_ACK: complete=ack_out=1 for one cycle, then IDLE.
- Timeout counter:
  - Cleared on entry to WAIT_RESP/READ and in every other state.
  - Increments each cycle in WAIT_RESP/READ and saturates at timeout_reg.
  - When count == timeout_reg and timeout_reg != 0: set data_timeout, go to WAIT_ACK.
  - If reception_complete arrives in the same cycle as the timeout hit, reception wins and no timeout is flagged.
- blocks_done is BLK_W wide and saturates at all-ones.

## Timing
- Reset (asynchronous) forces state IDLE. Output values in reset/IDLE:
  - serial_ready=1, reset_wrapper=1.
  - All other 1-bit outputs 0.
  - data_parallel, data_to_fifo, blocks_done and the timeout counter all 0.
- Reset mid-transfer aborts immediately. No push or pop occurs in the reset cycle.
- idle_in: next state is IDLE from any state, with priority below reset and above all transitions. Error flags clear on re-entry to IDLE.
- Write latency with a non-empty FIFO: strobe sampled at edge 0, fifo_pop high in cycle 1, LOAD in cycle 2, load_send first high in cycle 3.
- Read: first fifo_push occurs 1 cycle after reception_complete when the FIFO is not full.
- Error flags hold until the next strobe accepted in IDLE, or until idle_in.
- With timeout_reg=T, data_timeout rises T cycles after entering WAIT_RESP/READ; the state is WAIT_ACK on the next cycle.

## Test plan
- Single-block write, blocks=1, multiple=0, FIFO holds 0xA5A5_0001:
  - exactly one fifo_pop; data_parallel=0xA5A5_0001 in LOAD.
  - after reception_complete with crc_ok=1: blocks_done=1, complete=1; after ack_in, one-cycle ack_out, then IDLE.
- Multi-block read, blocks=3, three reception_complete pulses:
  - three fifo_push pulses carrying data_read values.
  - BLK_RESET seen twice; blocks_done=3; WAIT_ACK.
- Read with fifo_full held 5 cycles at PUSH: fifo_push stays 0 for those 5 cycles, then pulses exactly once; no word lost.
- timeout_reg=4, read with no reception:
  - data_timeout=1 four cycles after entering READ; WAIT_ACK next cycle.
  - timeout_reg=0 instead: controller stays in READ for 1000 cycles with no flag.
- Write with crc_ok=0: crc_error=1, blocks_done stays 0, WAIT_ACK; the next strobe clears crc_error.
- idle_in asserted in SEND, and reset asserted asynchronously in WAIT_RESP: both reach IDLE with the reset values listed under Timing.
